// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage in front of a combinational
// instruction memory. Owns the PC, presents it as the fetch address and
// captures the returned word into the IF/ID register for decode.
// Handles stall, flush and redirect from later stages.
//
// Build option: define FETCH_ADDR_CHECK_EN to enable fetch-address
// checking (misaligned or out-of-range PC drives the sticky FAULT state).
// Without it no checking is done, fetch_fault is tied low and the memory
// address is always word-aligned.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE = 32'h0000_8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN = 1'b0, FAULT = 1'b1} state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_p0;
  logic [31:0] pc_plus4_p0;
  logic        addr_bad;

  // Next sequential PC; 32-bit add wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

`ifdef FETCH_ADDR_CHECK_EN
  // Legal fetch: word aligned and no further than the last memory word.
  function automatic logic addr_legal(input logic [31:0] pc);
    return (pc[1:0] == 2'b00) && (pc <= (MEM_SIZE - 32'd4));
  endfunction

  // The check looks at the PC currently presented, so a bad redirect
  // target is caught on the first cycle it sits in the PC.
  assign addr_bad     = (state == RUN) && !addr_legal(pc_p0);
  assign imem_address = pc_p0;
`else
  assign addr_bad     = 1'b0;
  assign imem_address = {pc_p0[31:2], 2'b00};
`endif

  assign pc_plus4_p0 = pc_inc(pc_p0);

  // State register: reset always returns to RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  // Next state: a bad fetch address in RUN traps; FAULT is left only by reset.
  always_comb begin
    state_nx = state;
    if (state == RUN && addr_bad) begin
      state_nx = FAULT;
    end
  end

  // Output decode: fault flag is the FAULT state itself, which makes it sticky.
  always_comb begin
`ifdef FETCH_ADDR_CHECK_EN
    fetch_fault = (state == FAULT);
`else
    fetch_fault = 1'b0;
`endif
  end

  // PC and IF/ID update, priority: fault detect > redirect > stall > sequential.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p0             <= RESET_PC;
      if_id_instruction <= NOP;
      if_id_pc          <= 32'h0000_0000;
      if_id_pc_plus4    <= 32'h0000_0000;
      if_id_valid       <= 1'b0;
      fetch_count       <= 32'h0000_0000;
    end else if (state == RUN) begin
      if (addr_bad) begin
        // Trap: PC frozen on the offending address, IF/ID drained.
        if_id_valid <= 1'b0;
      end else if (redirect) begin
        // Taken branch/jump: the word fetched this cycle is wrong-path.
        pc_p0             <= redirect_target;
        if_id_instruction <= NOP;
        if_id_valid       <= 1'b0;
      end else if (stall) begin
        // Hold everything, but a concurrent flush still kills IF/ID.
        if (flush) begin
          if_id_instruction <= NOP;
          if_id_valid       <= 1'b0;
        end
      end else if (flush) begin
        // Flush drops the fetched word yet the PC keeps moving.
        pc_p0             <= pc_plus4_p0;
        if_id_instruction <= NOP;
        if_id_valid       <= 1'b0;
      end else begin
        pc_p0             <= pc_plus4_p0;
        if_id_instruction <= imem_instruction;
        if_id_pc          <= pc_p0;
        if_id_pc_plus4    <= pc_plus4_p0;
        if_id_valid       <= 1'b1;
        fetch_count       <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a small combinational instruction
// memory model: words 0..3 hold 0x11..0x44, word i (i>=4) holds 0xA000_0000+i.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];
  int checks   = 0;
  int failures = 0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .MEM_SIZE(32'h0000_8000)) dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .flush(flush),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .imem_address(imem_address),
    .imem_instruction(imem_instruction),
    .if_id_instruction(if_id_instruction),
    .if_id_pc(if_id_pc),
    .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  assign imem_instruction = mem[imem_address[7:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_addr"},  imem_address, 32'h0);
    check({tag, "_instr"}, if_id_instruction, 32'h0);
    check({tag, "_pc"},    if_id_pc, 32'h0);
    check({tag, "_pc4"},   if_id_pc_plus4, 32'h0);
    check({tag, "_valid"}, {31'b0, if_id_valid}, 32'h0);
    check({tag, "_fault"}, {31'b0, fetch_fault}, 32'h0);
    check({tag, "_count"}, fetch_count, 32'h0);
  endtask

  initial begin
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    for (int i = 4; i < 64; i++) mem[i] = 32'hA000_0000 + i;

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    step(2);
    check_reset_values("rst");

    // Four sequential fetches
    reset = 1'b0;
    step(1);
    check("seq1_instr", if_id_instruction, 32'h11);
    check("seq1_pc", if_id_pc, 32'h0);
    check("seq1_valid", {31'b0, if_id_valid}, 32'h1);
    step(1);
    check("seq2_instr", if_id_instruction, 32'h22);
    check("seq2_pc", if_id_pc, 32'h4);
    step(1);
    check("seq3_instr", if_id_instruction, 32'h33);
    check("seq3_pc", if_id_pc, 32'h8);
    step(1);
    check("seq4_instr", if_id_instruction, 32'h44);
    check("seq4_pc", if_id_pc, 32'hC);
    check("seq4_pc4", if_id_pc_plus4, 32'h10);
    check("seq4_count", fetch_count, 32'h4);
    check("seq4_addr", imem_address, 32'h10);

    // Stall for three cycles after the second fetch
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(2);
    check("pre_stall_pc", if_id_pc, 32'h4);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("stall_pc", if_id_pc, 32'h4);
      check("stall_addr", imem_address, 32'h8);
      check("stall_count", fetch_count, 32'h2);
    end
    stall = 1'b0;
    step(1);
    check("unstall_pc", if_id_pc, 32'h8);
    check("unstall_instr", if_id_instruction, 32'h33);
    check("unstall_count", fetch_count, 32'h3);
    check("unstall_addr", imem_address, 32'hC);

    // Redirect with stall: redirect wins, one bubble
    redirect = 1'b1; redirect_target = 32'h40; stall = 1'b1;
    step(1);
    check("redir_addr", imem_address, 32'h40);
    check("redir_valid", {31'b0, if_id_valid}, 32'h0);
    check("redir_instr", if_id_instruction, 32'h0);
    check("redir_count", fetch_count, 32'h3);
    redirect = 1'b0; stall = 1'b0;
    step(1);
    check("redir2_pc", if_id_pc, 32'h40);
    check("redir2_instr", if_id_instruction, 32'hA000_0010);
    check("redir2_valid", {31'b0, if_id_valid}, 32'h1);
    check("redir2_count", fetch_count, 32'h4);

    // Single-cycle flush: bubble, PC advances, count holds
    flush = 1'b1;
    step(1);
    check("flush_valid", {31'b0, if_id_valid}, 32'h0);
    check("flush_instr", if_id_instruction, 32'h0);
    check("flush_addr", imem_address, 32'h48);
    check("flush_count", fetch_count, 32'h4);
    flush = 1'b0;
    step(1);
    check("postflush_pc", if_id_pc, 32'h48);
    check("postflush_instr", if_id_instruction, 32'hA000_0012);
    check("postflush_count", fetch_count, 32'h5);

    // Flush with stall: IF/ID killed, PC held
    flush = 1'b1; stall = 1'b1;
    step(1);
    check("fstall_valid", {31'b0, if_id_valid}, 32'h0);
    check("fstall_instr", if_id_instruction, 32'h0);
    check("fstall_addr", imem_address, 32'h4C);
    check("fstall_count", fetch_count, 32'h5);
    flush = 1'b0; stall = 1'b0;
    step(1);
    check("postfs_pc", if_id_pc, 32'h4C);
    check("postfs_instr", if_id_instruction, 32'hA000_0013);
    check("postfs_count", fetch_count, 32'h6);

    // Reset asserted mid-stall
    stall = 1'b1; reset = 1'b1;
    step(1);
    check_reset_values("rst_stall");
    stall = 1'b0; reset = 1'b0;

    // Redirect to a misaligned target
    redirect = 1'b1; redirect_target = 32'h42;
    step(1);
    redirect = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
    check("bad_addr_presented", imem_address, 32'h42);
    check("bad_fault_not_yet", {31'b0, fetch_fault}, 32'h0);
    step(1);
    check("bad_fault", {31'b0, fetch_fault}, 32'h1);
    check("bad_valid", {31'b0, if_id_valid}, 32'h0);
    redirect = 1'b1; redirect_target = 32'h0;
    step(1);
    redirect = 1'b0;
    check("fault_ignores_redir", imem_address, 32'h42);
    check("fault_sticky", {31'b0, fetch_fault}, 32'h1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_reset_values("rst_fault");
`else
    check("mis_addr", imem_address, 32'h40);
    check("mis_fault", {31'b0, fetch_fault}, 32'h0);
    step(1);
    check("mis_instr", if_id_instruction, 32'hA000_0010);
    check("mis_pc", if_id_pc, 32'h42);
    check("mis_fault2", {31'b0, fetch_fault}, 32'h0);
    check("mis_addr2", imem_address, 32'h44);

    // PC wrap modulo 2^32
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(1);
    redirect = 1'b0;
    check("wrap_addr", imem_address, 32'hFFFF_FFFC);
    step(1);
    check("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_id_pc_plus4, 32'h0);
    check("wrap_instr", if_id_instruction, 32'hA000_003F);
    check("wrap_addr2", imem_address, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
